// File: rtl/pwm_ramp_ctrl_if.sv
// Interface between the switch/PWM side and the ramp controller.
// The master drives the request and the period reference; the slave returns the duty word and status.
interface pwm_ramp_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] target;
    logic             enable;
    logic             period_end;
    logic [3:0]       ramp_rate;
    logic [WIDTH-1:0] duty;
    logic             duty_load;
    logic             busy;
    logic             at_target;

    modport master (
        output target, enable, period_end, ramp_rate,
        input  duty, duty_load, busy, at_target
    );

    modport slave (
        input  target, enable, period_end, ramp_rate,
        output duty, duty_load, busy, at_target
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer: qualifies the switch target and ramps the PWM duty
// toward it in STEP increments, changing duty only on PWM period boundaries.
module pwm_ramp_ctrl #(
    parameter int WIDTH      = 8,
    parameter int STEP       = 4,
    parameter int STABLE_CYC = 1000
) (
    input  logic            clk,
    input  logic            clr,
    pwm_ramp_ctrl_if.slave  bus
);
    localparam int CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CW-1:0]    STAB_MAX = CW'(STABLE_CYC - 1);
    localparam logic [WIDTH:0]   STEP_W   = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] STEP_N   = WIDTH'(STEP);

    typedef enum logic [1:0] {HOLD, RAMP_UP, RAMP_DOWN} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sync1_reg, sync2_reg, tgt_acc_reg;
    logic [CW-1:0]    stab_cnt_reg;
    logic [3:0]       rate_cnt_reg, rate_cnt_next;
    logic [WIDTH-1:0] duty_reg, duty_next;
    logic             duty_load_reg, duty_load_next;
    logic             busy_reg, busy_next;
    logic             at_target_reg, at_target_next;

    logic [WIDTH-1:0] goal;
    logic [WIDTH:0]   up_diff, dn_diff;
    logic [WIDTH-1:0] up_val, dn_val;

    // Target qualification: a new value is accepted only after holding steady on the synchronized side.
    always_ff @(posedge clk) begin
        if (!clr) begin
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            stab_cnt_reg <= '0;
            tgt_acc_reg  <= '0;
        end else begin
            sync1_reg <= bus.target;
            sync2_reg <= sync1_reg;
            if (sync1_reg != sync2_reg)
                stab_cnt_reg <= '0;
            else if (stab_cnt_reg != STAB_MAX)
                stab_cnt_reg <= stab_cnt_reg + CW'(1);
            if ((stab_cnt_reg == STAB_MAX) && (sync2_reg != tgt_acc_reg))
                tgt_acc_reg <= sync2_reg;
        end
    end

    assign goal    = bus.enable ? tgt_acc_reg : '0;
    // Distances are taken one bit wider so the clamp test never sees a wrapped value.
    assign up_diff = {1'b0, goal} - {1'b0, duty_reg};
    assign dn_diff = {1'b0, duty_reg} - {1'b0, goal};
    assign up_val  = (up_diff <= STEP_W) ? goal : duty_reg + STEP_N;
    assign dn_val  = (dn_diff <= STEP_W) ? goal : duty_reg - STEP_N;

    always_comb begin
        state_next     = state_reg;
        duty_next      = duty_reg;
        rate_cnt_next  = rate_cnt_reg;
        if ((state_reg != HOLD) && bus.period_end) begin
            if (rate_cnt_reg == bus.ramp_rate) begin
                rate_cnt_next = '0;
                // Step direction follows the live comparison so a reversal never overshoots.
                if (goal > duty_reg)
                    duty_next = up_val;
                else if (goal < duty_reg)
                    duty_next = dn_val;
            end else begin
                rate_cnt_next = rate_cnt_reg + 4'd1;
            end
        end
        if (goal > duty_next)
            state_next = RAMP_UP;
        else if (goal < duty_next)
            state_next = RAMP_DOWN;
        else
            state_next = HOLD;
        if (state_next == HOLD)
            rate_cnt_next = '0;
        duty_load_next = (duty_next != duty_reg);
        busy_next      = (state_next != HOLD);
        at_target_next = (state_next == HOLD) && (duty_next == goal);
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_reg     <= HOLD;
            rate_cnt_reg  <= '0;
            duty_reg      <= '0;
            duty_load_reg <= 1'b0;
            busy_reg      <= 1'b0;
            at_target_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            rate_cnt_reg  <= rate_cnt_next;
            duty_reg      <= duty_next;
            duty_load_reg <= duty_load_next;
            busy_reg      <= busy_next;
            at_target_reg <= at_target_next;
        end
    end

    assign bus.duty      = duty_reg;
    assign bus.duty_load = duty_load_reg;
    assign bus.busy      = busy_reg;
    assign bus.at_target = at_target_reg;
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: a vector table of ramp segments plus hand-written
// sequences for reset, requalification latency and target chatter.
module tb_pwm_ramp_ctrl;
    localparam int PERIOD = 20;
    localparam int SETTLE = 10;
    localparam int NVEC   = 12;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    pwm_ramp_ctrl_if #(.WIDTH(8)) bus ();

    pwm_ramp_ctrl #(.WIDTH(8), .STEP(4), .STABLE_CYC(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] target;
        logic       enable;
        logic [3:0] rate;
        int         periods;
        logic [7:0] exp_duty;
        logic       exp_busy;
        logic       exp_at;
        int         exp_loads;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Idle clock: duty must neither move nor be loaded without a period_end.
    task automatic idle_clock(inout logic [7:0] prev, inout int glitch);
        tick();
        if (bus.duty_load || (bus.duty !== prev)) glitch++;
        prev = bus.duty;
    endtask

    task automatic run_vector(input int idx);
        int         loads  = 0;
        int         glitch = 0;
        logic [7:0] prev;
        bus.target    = vecs[idx].target;
        bus.enable    = vecs[idx].enable;
        bus.ramp_rate = vecs[idx].rate;
        prev = bus.duty;
        repeat (SETTLE) idle_clock(prev, glitch);
        for (int p = 0; p < vecs[idx].periods; p++) begin
            bus.period_end = 1'b1;
            tick();
            bus.period_end = 1'b0;
            if (bus.duty_load) begin
                loads++;
                if (bus.duty === prev) glitch++;
            end else if (bus.duty !== prev) begin
                glitch++;
            end
            prev = bus.duty;
            repeat (PERIOD - 1) idle_clock(prev, glitch);
        end
        $display("vec%0d target=%02h en=%0b rate=%0d periods=%0d -> duty=%02h busy=%0b at_target=%0b loads=%0d",
                 idx, vecs[idx].target, vecs[idx].enable, vecs[idx].rate, vecs[idx].periods,
                 bus.duty, bus.busy, bus.at_target, loads);
        check($sformatf("vec%0d duty", idx), 32'(bus.duty), 32'(vecs[idx].exp_duty));
        check($sformatf("vec%0d busy", idx), 32'(bus.busy), 32'(vecs[idx].exp_busy));
        check($sformatf("vec%0d at_target", idx), 32'(bus.at_target), 32'(vecs[idx].exp_at));
        check($sformatf("vec%0d loads", idx), 32'(loads), 32'(vecs[idx].exp_loads));
        check($sformatf("vec%0d glitch", idx), 32'(glitch), 32'd0);
    endtask

    // After clr release the target needs 6 clocks to be accepted and one more to start ramping;
    // a period_end inside that window arrives while still in HOLD and must be ignored.
    task automatic release_sequence(input string tag);
        clr = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            if (i == 3) bus.period_end = 1'b1;
            tick();
            bus.period_end = 1'b0;
            if (i == 3) begin
                check({tag, " hold ignores period_end load"}, 32'(bus.duty_load), 32'd0);
                check({tag, " hold ignores period_end duty"}, 32'(bus.duty), 32'd0);
            end
            if (i == 6) begin
                check({tag, " busy before accept"}, 32'(bus.busy), 32'd0);
                check({tag, " at_target before accept"}, 32'(bus.at_target), 32'd1);
            end
            if (i == 7) begin
                check({tag, " busy after accept"}, 32'(bus.busy), 32'd1);
                check({tag, " at_target after accept"}, 32'(bus.at_target), 32'd0);
            end
        end
        $display("%s release: busy=%0b duty=%02h", tag, bus.busy, bus.duty);
    endtask

    initial begin
        int loads;
        int changes;

        //          target  en    rate  per  duty   busy  at    loads
        vecs[0]  = '{8'h80, 1'b1, 4'd0, 31, 8'h7C, 1'b1, 1'b0, 31};
        vecs[1]  = '{8'h80, 1'b1, 4'd0,  1, 8'h80, 1'b0, 1'b1,  1};
        vecs[2]  = '{8'h7E, 1'b1, 4'd0,  1, 8'h7E, 1'b0, 1'b1,  1};
        vecs[3]  = '{8'h7E, 1'b1, 4'd0,  1, 8'h7E, 1'b0, 1'b1,  0};
        vecs[4]  = '{8'h20, 1'b1, 4'd0, 24, 8'h20, 1'b0, 1'b1, 24};
        vecs[5]  = '{8'h80, 1'b1, 4'd0,  8, 8'h40, 1'b1, 1'b0,  8};
        vecs[6]  = '{8'h80, 1'b0, 4'd0,  1, 8'h3C, 1'b1, 1'b0,  1};
        vecs[7]  = '{8'h80, 1'b0, 4'd0, 15, 8'h00, 1'b0, 1'b1, 15};
        vecs[8]  = '{8'h80, 1'b0, 4'd0,  2, 8'h00, 1'b0, 1'b1,  0};
        vecs[9]  = '{8'h0C, 1'b1, 4'd3, 11, 8'h08, 1'b1, 1'b0,  2};
        vecs[10] = '{8'h0C, 1'b1, 4'd3,  1, 8'h0C, 1'b0, 1'b1,  1};
        vecs[11] = '{8'h60, 1'b1, 4'd0,  9, 8'h30, 1'b1, 1'b0,  9};

        bus.target     = 8'h80;
        bus.enable     = 1'b1;
        bus.ramp_rate  = 4'd0;
        bus.period_end = 1'b0;
        clr            = 1'b0;
        repeat (3) tick();
        check("reset duty", 32'(bus.duty), 32'd0);
        check("reset duty_load", 32'(bus.duty_load), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset at_target", 32'(bus.at_target), 32'd1);
        release_sequence("start");

        for (int v = 0; v <= 10; v++) run_vector(v);

        // Chatter between 0x10 and 0x20 must never be accepted.
        loads   = 0;
        changes = 0;
        for (int c = 0; c < 50; c++) begin
            bus.target     = ((c / 2) % 2 == 0) ? 8'h10 : 8'h20;
            bus.period_end = (c % 10 == 9);
            tick();
            bus.period_end = 1'b0;
            if (bus.duty_load) loads++;
            if (bus.duty !== 8'h0C) changes++;
        end
        bus.target = 8'h0C;
        repeat (SETTLE) tick();
        $display("chatter: loads=%0d duty_changes=%0d duty=%02h at_target=%0b", loads, changes, bus.duty, bus.at_target);
        check("chatter loads", 32'(loads), 32'd0);
        check("chatter duty changes", 32'(changes), 32'd0);
        check("chatter at_target", 32'(bus.at_target), 32'd1);

        run_vector(11);

        // One-clock reset mid-ramp at 0x30.
        clr = 1'b0;
        tick();
        $display("midramp reset: duty=%02h busy=%0b at_target=%0b duty_load=%0b", bus.duty, bus.busy, bus.at_target, bus.duty_load);
        check("midramp reset duty", 32'(bus.duty), 32'd0);
        check("midramp reset busy", 32'(bus.busy), 32'd0);
        check("midramp reset at_target", 32'(bus.at_target), 32'd1);
        check("midramp reset duty_load", 32'(bus.duty_load), 32'd0);
        release_sequence("midramp");
        bus.period_end = 1'b1;
        tick();
        bus.period_end = 1'b0;
        $display("restart step: duty=%02h duty_load=%0b", bus.duty, bus.duty_load);
        check("restart step duty", 32'(bus.duty), 32'h04);
        check("restart step duty_load", 32'(bus.duty_load), 32'd1);
        tick();
        check("restart load pulse width", 32'(bus.duty_load), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Soft-start/soft-stop sequencer for the 8-bit PWM generator. It qualifies the raw switch target and ramps the duty word fed to the PWM block toward that target in fixed steps. Duty updates are issued only at PWM period boundaries, so the output never glitches mid-period. It sits between the board switches and the PWM duty input, and takes the generator's period-wrap pulse as its timing reference.

Parameters:
WIDTH, 8, duty/target width in bits
STEP, 4, duty increment/decrement applied per ramp step (1..2^WIDTH-1)
STABLE_CYC, 1000, consecutive clocks the synchronized target must hold before acceptance (>=1)

Ports:
clk  input  1  system clock, all logic rising-edge
clr  input  1  reset, synchronous, active-low
target  input  WIDTH  requested duty from switches (asynchronous, unsynchronized)
enable  input  1  1 = ramp toward target; 0 = ramp toward 0
period_end  input  1  one-clock pulse from PWM counter wrap
ramp_rate  input  4  PWM periods per step minus 1 (0 = step every period)
duty  output  WIDTH  registered duty word to PWM
duty_load  output  1  one-clock pulse, high in the cycle duty changes
busy  output  1  high while ramping
at_target  output  1  high when duty equals the effective goal and no ramp is pending

Behaviour:
- Reset (clr=0 at clk edge): duty=0, duty_load=0, busy=0, at_target=1, tgt_acc=0, sync flops=0, stability counter=0, rate counter=0, state=HOLD. Reset mid-ramp aborts the ramp immediately. No period alignment is applied on reset.
- Target qualification:
  - target passes through a 2-flop synchronizer to give tgt_s.
  - A stability counter clears whenever tgt_s changes and otherwise increments, saturating.
  - When the count reaches STABLE_CYC-1 and tgt_s != tgt_acc, tgt_acc <= tgt_s.
  - Latency from a stable input change to tgt_acc update is STABLE_CYC+2 clocks.
- Effective goal: goal = enable ? tgt_acc : 0.
- States: HOLD, RAMP_UP, RAMP_DOWN. Evaluated every clock:
  - HOLD -> RAMP_UP if goal > duty; HOLD -> RAMP_DOWN if goal < duty.
  - RAMP_UP/RAMP_DOWN -> HOLD when duty == goal after a step.
  - RAMP_UP <-> RAMP_DOWN directly if goal crosses duty mid-ramp. Reversal is immediate; no return to HOLD.
- Step timing:
  - In RAMP states, each period_end increments the rate counter.
  - If the counter equals ramp_rate at that period_end, the counter clears and a step occurs.
  - The new duty is registered on the same edge, so it is visible the cycle after period_end, and duty_load=1 for exactly that cycle.
  - ramp_rate is sampled at each period_end.
  - The rate counter clears on entry to HOLD.
- Step arithmetic (WIDTH+1 bit internal, no wrap):
  - Up: duty <= (goal - duty <= STEP) ? goal : duty + STEP.
  - Down: duty <= (duty - goal <= STEP) ? goal : duty - STEP.
  - No overshoot, no wrap past 0 or 2^WIDTH-1.
- duty changes only on step cycles and reset. It never changes in a cycle without a preceding period_end.
- busy = (state != HOLD). at_target = (state == HOLD) && (duty == goal). Both are registered with state.
- Simultaneous events:
  - tgt_acc update on the same edge as a step: the step uses the old tgt_acc, and direction re-evaluates next clock.
  - enable falling during a ramp up: direction reverses toward 0 at the next evaluation.
  - period_end while in HOLD: ignored.

Test Plan:
1. Reset with target=0x80, enable=1, ramp_rate=0, STEP=4, STABLE_CYC=4, period_end every 256 clocks -> after release, tgt_acc=0x80 at clock 6. duty steps 0,4,8..0x80 with one step per period_end (32 steps). duty_load pulses 32 times, each one clock after a period_end. busy=1 throughout, then at_target=1.
2. From duty=0x80, set target=0x7E -> one step down to 0x7E (clamped, not 0x7C), then HOLD, at_target=1.
3. target toggles 0x10/0x20 every 2 clocks for 50 clocks with STABLE_CYC=4 -> tgt_acc unchanged, no duty_load.
4. Mid-ramp at duty=0x40 heading to 0x80, drop enable -> next step gives 0x3C, ramp down to 0x00, no overshoot below 0.
5. ramp_rate=3, ramp 0->0x0C -> steps only on every 4th period_end; 3 steps over 12 periods.
6. Assert clr=0 for one clock mid-ramp at duty=0x30 -> next cycle duty=0, busy=0, at_target=1, duty_load=0; after release, the ramp restarts from 0 only after target requalification.
